// File: rtl/pci_pkg.sv
// pci_pkg: shared definitions for the PCI bus model.
//   arb_state_t  - arbiter FSM states
//   DEV_*_ADDR   - device address constants for devices A, B, C
//   CMD_*        - PCI command codes used by the devices
package pci_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      TURN  = 2'd3
   } arb_state_t;

   localparam logic [7:0] DEV_A_ADDR = 8'hAD;
   localparam logic [7:0] DEV_B_ADDR = 8'hBD;
   localparam logic [7:0] DEV_C_ADDR = 8'hCD;

   localparam logic [3:0] CMD_WRITE = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0010;

endpackage

// File: rtl/pci_rr_picker.sv
// pci_rr_picker: combinational round-robin requester selection.
//   req_n_i      - active-low request vector
//   last_owner_i - index served most recently (lowest priority now)
//   valid_o      - at least one request is pending
//   idx_o        - first requester strictly after last_owner_i, with wrap
module pci_rr_picker #(
   parameter int N = 3,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_n_i,
   input  logic [W-1:0] last_owner_i,
   output logic         valid_o,
   output logic [W-1:0] idx_o
);

   always_comb begin
      int idx;
      idx     = 0;
      valid_o = 1'b0;
      idx_o   = '0;
      // Offset 1..N visits every index once, ending on last_owner itself,
      // so a lone requester that was just served still wins.
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last_owner_i) + k) % N;
         if (!valid_o && !req_n_i[idx]) begin
            valid_o = 1'b1;
            idx_o   = W'(idx);
         end
      end
   end

endmodule

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: central round-robin arbiter for the shared PCI bus.
//   clk, rst  - bus clock, synchronous active-high reset
//   REQ       - active-low requests from devices (index 0..2 = A, B, C)
//   GNT       - active-low grants, at most one low at a time (registered)
//   FRAME     - bus FRAME, observed only, active low
//   IRDY      - bus IRDY, observed only, active low
//   owner     - index of current or most recent grantee (registered)
//   bus_busy  - high in GRANT and BUSY (registered)
// Optional feature: define PCI_ARB_GNT_TIMEOUT_EN to revoke a grant whose
// master does not start a transaction within GNT_TIMEOUT cycles.
import pci_pkg::*;

module pci_bus_arbiter #(
   parameter int N_MASTERS   = 3,
   parameter int GNT_TIMEOUT = 16,
   parameter int OWN_W       = $clog2(N_MASTERS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] REQ,
   output logic [N_MASTERS-1:0] GNT,
   input  logic                 FRAME,
   input  logic                 IRDY,
   output logic [OWN_W-1:0]     owner,
   output logic                 bus_busy
);

   arb_state_t             state_q, state_d;
   logic [N_MASTERS-1:0]   gnt_q, gnt_d;
   logic [OWN_W-1:0]       owner_q, owner_d;
   logic [OWN_W-1:0]       last_q, last_d;
   logic                   busy_q, busy_d;
   logic                   pick_valid;
   logic [OWN_W-1:0]       pick_idx;
   logic                   expired;
   logic                   bus_idle;

   assign bus_idle = FRAME && IRDY;

   pci_rr_picker #(.N(N_MASTERS), .W(OWN_W)) u_picker (
      .req_n_i      (REQ),
      .last_owner_i (last_q),
      .valid_o      (pick_valid),
      .idx_o        (pick_idx)
   );

`ifdef PCI_ARB_GNT_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(GNT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GNT_TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

   // Count includes the current GRANT cycle, so expiry lands after exactly
   // GNT_TIMEOUT cycles with the grant asserted. Saturates at CNT_MAX.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign expired = (cnt_inc == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE)       cnt_d = '0;
      else if (state_q == GRANT) cnt_d = cnt_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (bus_idle && pick_valid) begin
               gnt_d           = '1;
               gnt_d[pick_idx] = 1'b0;
               owner_d         = pick_idx;
               busy_d          = 1'b1;
               state_d         = GRANT;
            end
         end
         GRANT: begin
            // FRAME falling wins over a same-cycle withdrawal or expiry.
            if (!FRAME) begin
               state_d = BUSY;
            end else if (REQ[owner_q] || expired) begin
               gnt_d   = '1;
               busy_d  = 1'b0;
               state_d = TURN;
            end
         end
         BUSY: begin
            if (bus_idle) begin
               gnt_d   = '1;
               busy_d  = 1'b0;
               state_d = TURN;
            end
         end
         TURN: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '1;
         owner_q <= '0;
         last_q  <= OWN_W'(N_MASTERS - 1);
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   assign GNT      = gnt_q;
   assign owner    = owner_q;
   assign bus_busy = busy_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed vector table plus hand-written sequences for
// round-robin rotation and grant timeout behaviour of pci_bus_arbiter.
module tb_pci_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] REQ;
   logic       FRAME;
   logic       IRDY;
   logic [2:0] GNT;
   logic [1:0] owner;
   logic       bus_busy;

   int checks = 0;
   int errors = 0;

   pci_bus_arbiter #(.N_MASTERS(3), .GNT_TIMEOUT(4), .OWN_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .REQ      (REQ),
      .GNT      (GNT),
      .FRAME    (FRAME),
      .IRDY     (IRDY),
      .owner    (owner),
      .bus_busy (bus_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic       frame;
      logic       irdy;
      logic [2:0] gnt;
      logic [1:0] own;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [2:0] q, input logic f,
                      input logic i, input logic [2:0] g, input logic [1:0] o,
                      input logic b);
      vec_t v;
      v.rst = r; v.req = q; v.frame = f; v.irdy = i;
      v.gnt = g; v.own = o; v.busy = b;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // At most one grant low on any cycle.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if ($countones(~GNT) > 1) begin
            errors++;
            $display("FAIL onehot_gnt: got %b expected at most one low bit", GNT);
         end
      end
   end

   initial begin
      logic [2:0] e;
      int         gap;
      int         lows;

      rst = 1'b1; REQ = 3'b111; FRAME = 1'b1; IRDY = 1'b1;

      // single requester, 4-cycle FRAME, re-grant, withdrawal
      add(1, 3'b111, 1, 1, 3'b111, 2'd0, 0);
      add(0, 3'b110, 1, 1, 3'b110, 2'd0, 1);
      add(0, 3'b110, 0, 1, 3'b110, 2'd0, 1);
      add(0, 3'b110, 0, 1, 3'b110, 2'd0, 1);
      add(0, 3'b110, 0, 1, 3'b110, 2'd0, 1);
      add(0, 3'b110, 0, 1, 3'b110, 2'd0, 1);
      add(0, 3'b110, 1, 1, 3'b111, 2'd0, 0);
      add(0, 3'b110, 1, 1, 3'b111, 2'd0, 0);
      add(0, 3'b110, 1, 1, 3'b110, 2'd0, 1);
      add(0, 3'b111, 1, 1, 3'b111, 2'd0, 0);
      add(0, 3'b111, 1, 1, 3'b111, 2'd0, 0);
      // REQ[1] withdrawn in GRANT, pending REQ[2] served next; IRDY holds BUSY
      add(1, 3'b111, 1, 1, 3'b111, 2'd0, 0);
      add(0, 3'b001, 1, 1, 3'b101, 2'd1, 1);
      add(0, 3'b011, 1, 1, 3'b111, 2'd1, 0);
      add(0, 3'b011, 1, 1, 3'b111, 2'd1, 0);
      add(0, 3'b011, 1, 1, 3'b011, 2'd2, 1);
      add(0, 3'b011, 0, 1, 3'b011, 2'd2, 1);
      add(0, 3'b011, 1, 0, 3'b011, 2'd2, 1);
      add(0, 3'b011, 1, 1, 3'b111, 2'd2, 0);
      add(0, 3'b111, 1, 1, 3'b111, 2'd2, 0);
      // busy bus blocks a grant from IDLE
      add(0, 3'b101, 0, 1, 3'b111, 2'd2, 0);
      add(0, 3'b101, 1, 0, 3'b111, 2'd2, 0);
      add(0, 3'b101, 1, 1, 3'b101, 2'd1, 1);
      add(0, 3'b101, 0, 1, 3'b101, 2'd1, 1);
      // reset mid-BUSY, then index order restarts at 0
      add(1, 3'b101, 0, 1, 3'b111, 2'd0, 0);
      add(0, 3'b000, 1, 1, 3'b110, 2'd0, 1);
      add(0, 3'b111, 1, 1, 3'b111, 2'd0, 0);
      add(0, 3'b111, 1, 1, 3'b111, 2'd0, 0);

      foreach (vecs[n]) begin
         rst = vecs[n].rst; REQ = vecs[n].req;
         FRAME = vecs[n].frame; IRDY = vecs[n].irdy;
         tick();
         chk($sformatf("vec%0d gnt", n),  32'(GNT),      32'(vecs[n].gnt));
         chk($sformatf("vec%0d own", n),  32'(owner),    32'(vecs[n].own));
         chk($sformatf("vec%0d busy", n), 32'(bus_busy), 32'(vecs[n].busy));
      end

      // continuous load from all three: order 0,1,2,0,1,2, 2 idle cycles between
      rst = 1'b1; REQ = 3'b111; FRAME = 1'b1; IRDY = 1'b1;
      tick();
      rst = 1'b0; REQ = 3'b000;
      for (int t = 0; t < 6; t++) begin
         gap = 0;
         tick();
         for (int w = 0; w < 12 && GNT === 3'b111; w++) begin
            gap++;
            tick();
         end
         e = 3'b111;
         e[t % 3] = 1'b0;
         chk($sformatf("rr%0d gnt", t), 32'(GNT), 32'(e));
         chk($sformatf("rr%0d own", t), 32'(owner), 32'(t % 3));
         if (t > 0) chk($sformatf("rr%0d gap", t), 32'(gap), 32'd2);
         FRAME = 1'b0;
         tick(); tick();
         chk($sformatf("rr%0d busy", t), 32'(bus_busy), 32'd1);
         tick();
         FRAME = 1'b1;
      end
      REQ = 3'b111;
      tick(); tick();

      // stalled master: never asserts FRAME
      rst = 1'b1; REQ = 3'b111; FRAME = 1'b1; IRDY = 1'b1;
      tick();
      rst = 1'b0; REQ = 3'b100;
      tick();
      chk("stall gnt", 32'(GNT), 32'(3'b110));
      lows = 1;
      for (int c = 0; c < 120; c++) begin
         tick();
         if (GNT[0] !== 1'b0) break;
         lows++;
      end
`ifdef PCI_ARB_GNT_TIMEOUT_EN
      chk("timeout cycles", 32'(lows), 32'd4);
      chk("timeout turn", 32'(GNT), 32'(3'b111));
      tick();
      chk("timeout idle", 32'(GNT), 32'(3'b111));
      tick();
      chk("timeout next gnt", 32'(GNT), 32'(3'b101));
      chk("timeout next own", 32'(owner), 32'd1);
`else
      chk("no timeout hold", 32'(lows), 32'd121);
      chk("no timeout own", 32'(owner), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pci_bus_arbiter.md
# pci_bus_arbiter

Central arbiter for the shared PCI bus, directly upstream of every `Device`. It samples each device's active-low `REQ`, grants the bus to exactly one requester through its active-low `GNT`, and watches `FRAME`/`IRDY` so a new grant is never issued while a transaction is still in flight. Masters are served round-robin, so A, B and C get fair access under continuous load.

## Interface
- `N_MASTERS`, default 3: number of requester/grant pairs; index 0..2 map to devices A, B, C.
- `GNT_TIMEOUT`, default 16: cycles a granted master has to assert `FRAME` before the grant is revoked. Used only when the timeout feature is compiled in.
- `OWN_W`, default `$clog2(N_MASTERS)`: width of `owner`.

Ports:
- `clk`  in  1: bus clock. The arbiter acts on the rising edge only.
- `rst`  in  1: reset. Synchronous, active-high.
- `REQ`  in  N_MASTERS: request from each device, active low.
- `GNT`  out  N_MASTERS: grant to each device, active low. At most one bit is low at any time.
- `FRAME`  in  1: bus `FRAME`, observed only, active low.
- `IRDY`  in  1: bus `IRDY`, observed only, active low.
- `owner`  out  OWN_W: index of the current or most recent grantee.
- `bus_busy`  out  1: active high; set while the FSM is in GRANT or BUSY.

## Operation
- The FSM has four states: IDLE, GRANT, BUSY, TURN.
- **IDLE:** if the bus is idle (`FRAME`=1 and `IRDY`=1) and any `REQ` bit is 0:
  - pick the first requester strictly after `last_owner`, searching in ascending index order with wrap;
  - drive that `GNT` bit to 0, load `owner`, clear the timeout counter;
  - go to GRANT.
  - If no `REQ` is low, or the bus is not idle, stay in IDLE.
- **GRANT:**
  - `FRAME`=0: go to BUSY.
  - `REQ[owner]`=1 with `FRAME` still 1 (request withdrawn): go to TURN.
  - Timeout expired: go to TURN (see Configuration).
  - `GNT[owner]` stays 0 throughout GRANT.
- **BUSY:** `GNT[owner]` stays 0. Go to TURN on the first cycle where `FRAME`=1 and `IRDY`=1.
- **TURN:** one cycle with all `GNT` bits at 1. Set `last_owner` = `owner`, then go to IDLE.
- Round-robin rule:
  - after reset, `last_owner` = N_MASTERS-1, so index 0 has highest priority;
  - the master just served becomes lowest priority.
- Simultaneous requests are resolved by round-robin order only. A `REQ` that arrives during GRANT, BUSY or TURN waits for the next IDLE evaluation.
- A device holds `REQ` low across multiple transactions. It is re-granted only after every other pending requester has been served once.
- **Reset, including mid-operation:**
  - all `GNT` = 1, `owner` = 0, `bus_busy` = 0, state = IDLE, `last_owner` = N_MASTERS-1, counter = 0;
  - takes effect on the first rising edge with `rst`=1.

## Timing
- All outputs are registered and change only on the rising edge of `clk`. There is no combinational path from any input to any output.
- Grant latency: `REQ` low at rising edge k with the FSM in IDLE and the bus idle gives `GNT` low after edge k. The device samples that grant at edge k+1.
- Back-to-back grants: from `FRAME`/`IRDY` returning high at edge m:
  - edge m+1: FSM enters TURN;
  - edge m+2: FSM enters IDLE;
  - edge m+3: next `GNT` goes low.
  - This gives at least 2 idle cycles between owners.
- `bus_busy` is 1 during GRANT and BUSY, and 0 in IDLE and TURN.
- Timeout counter:
  - width `$clog2(GNT_TIMEOUT+1)`;
  - saturates and never wraps;
  - expires on the cycle where the count equals GNT_TIMEOUT, i.e. GNT_TIMEOUT cycles spent in GRANT.

## Configuration
- `PCI_ARB_GNT_TIMEOUT_EN` defined:
  - the counter runs in GRANT;
  - on expiry the FSM goes GRANT→TURN and the stalled master loses its turn, because round-robin advances past it.
- Not defined:
  - no counter is built and `GNT_TIMEOUT` is ignored;
  - GRANT is left only by `FRAME`=0, `REQ` withdrawal, or `rst`.

## Structure
- Shared package `pci_pkg` holds:
  - FSM state typedef `arb_state_t` (IDLE, GRANT, BUSY, TURN);
  - device address constants (0xAD, 0xBD, 0xCD);
  - command codes (write 4'b0011, read 4'b0010).
- Sub-module `pci_rr_picker`, combinational:
  - inputs: `req_n` vector and `last_owner`;
  - outputs: `valid` and the winning index.
- The arbiter top holds the FSM, `last_owner`, the timeout counter and the output registers.

## Test plan
- Reset mid-BUSY (`rst`=1 for 1 cycle): `GNT`=3'b111, `owner`=0, `bus_busy`=0 next edge; next request from idle is served in index order starting at 0.
- Single requester: `REQ`=3'b110 from reset; `GNT`=3'b110 one edge later. Hold `FRAME`=0 for 4 cycles, then 1 → `GNT`=3'b111 for 2 cycles.
- All three requesting continuously, each transaction with `FRAME` low for 3 cycles: grant order 0,1,2,0,1,2. Never two `GNT` bits low at once.
- Request withdrawal: `REQ[1]` low, then high in GRANT before `FRAME` falls → TURN, IDLE; pending `REQ[2]` granted next.
- With `PCI_ARB_GNT_TIMEOUT_EN` defined and `GNT_TIMEOUT`=4: granted master never asserts `FRAME` → `GNT` released after 4 GRANT cycles; next requester granted 2 edges later. Without the macro, `GNT` stays low for 100+ cycles.
- Grant blocked on a busy bus: `FRAME` held low by a prior owner while in IDLE → no `GNT` issued until `FRAME`=1 and `IRDY`=1.
